// File: rtl/tank_bullets.sv
// Bullet pool for the tank: infers facing from frame-to-frame tank motion, spawns
// on a fire-key press edge, then moves, bounces and expires each bullet per frame.
module tank_bullets #(
    parameter int         NUM_BULLETS = 4,
    parameter int         LIFETIME    = 600,
    parameter int         SPEED       = 2,
    parameter int         COOLDOWN    = 15,
    parameter logic [7:0] FIRE_KEY    = 8'h2C,
    parameter int         X_MAX       = 639,
    parameter int         Y_MAX       = 479
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic [31:0]               keycode,
    input  logic [9:0]                TankX,
    input  logic [9:0]                TankY,
    input  logic [9:0]                TankS,
    output logic [10*NUM_BULLETS-1:0] BulletX,
    output logic [10*NUM_BULLETS-1:0] BulletY,
    output logic [NUM_BULLETS-1:0]    BulletActive,
    output logic                      FireAck
);
    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    localparam int SLOT_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [9:0]      LIFE_INIT = 10'(LIFETIME);
    localparam logic [CD_W-1:0] CD_INIT   = CD_W'(COOLDOWN);
    localparam logic [10:0]     SPD11     = 11'(SPEED);
    localparam logic [9:0]      SPD10     = 10'(SPEED);
    localparam logic [10:0]     XLIM11    = 11'(X_MAX);
    localparam logic [10:0]     YLIM11    = 11'(Y_MAX);
    localparam logic [9:0]      XLIM10    = 10'(X_MAX);
    localparam logic [9:0]      YLIM10    = 10'(Y_MAX);

    logic [9:0]             r_prevX;
    logic [9:0]             r_prevY;
    dir_t                   r_dir;
    dir_t                   w_dirNext;
    logic                   r_firePrev;
    logic                   r_fireAck;
    logic [CD_W-1:0]        r_cooldown;
    logic [NUM_BULLETS-1:0] r_active;
    logic [9:0]             r_x    [NUM_BULLETS];
    logic [9:0]             r_y    [NUM_BULLETS];
    logic [9:0]             r_life [NUM_BULLETS];
    dir_t                   r_bdir [NUM_BULLETS];
    logic [9:0]             w_nx   [NUM_BULLETS];
    logic [9:0]             w_ny   [NUM_BULLETS];
    dir_t                   w_nd   [NUM_BULLETS];

    logic                   w_fireNow;
    logic                   w_fireEdge;
    logic [10:0]            w_tx;
    logic [10:0]            w_ty;
    logic [10:0]            w_ts;
    logic [10:0]            w_spawnX;
    logic [10:0]            w_spawnY;
    logic                   w_inRange;
    logic                   w_anyFree;
    logic [SLOT_W-1:0]      w_slot;
    logic                   w_spawn;

    assign w_fireNow  = (keycode[7:0]   == FIRE_KEY) || (keycode[15:8]  == FIRE_KEY) ||
                        (keycode[23:16] == FIRE_KEY) || (keycode[31:24] == FIRE_KEY);
    assign w_fireEdge = w_fireNow & ~r_firePrev;

    // X motion dominates Y; no motion keeps the previous facing.
    always_comb begin
        w_dirNext = r_dir;
        if (TankX > r_prevX) begin
            w_dirNext = DIR_RIGHT;
        end else if (TankX < r_prevX) begin
            w_dirNext = DIR_LEFT;
        end else if (TankY > r_prevY) begin
            w_dirNext = DIR_DOWN;
        end else if (TankY < r_prevY) begin
            w_dirNext = DIR_UP;
        end
    end

    assign w_tx = {1'b0, TankX};
    assign w_ty = {1'b0, TankY};
    assign w_ts = {1'b0, TankS};

    // Bit 10 acts as the sign of the 11-bit spawn coordinate.
    always_comb begin
        w_spawnX = w_tx;
        w_spawnY = w_ty;
        case (r_dir)
            DIR_RIGHT: w_spawnX = w_tx + w_ts + 11'd1;
            DIR_LEFT:  w_spawnX = w_tx - w_ts - 11'd1;
            DIR_DOWN:  w_spawnY = w_ty + w_ts + 11'd1;
            default:   w_spawnY = w_ty - w_ts - 11'd1;
        endcase
    end

    assign w_inRange = !w_spawnX[10] && !w_spawnY[10] &&
                       (w_spawnX <= XLIM11) && (w_spawnY <= YLIM11);

    always_comb begin
        w_anyFree = 1'b0;
        w_slot    = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_anyFree = 1'b1;
                w_slot    = SLOT_W'(i);
            end
        end
    end

    assign w_spawn = w_fireEdge && (r_cooldown == '0) && w_anyFree && w_inRange;

    // Landing exactly on a limit is legal; only overshoot clamps and reverses.
    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_nx[i] = r_x[i];
            w_ny[i] = r_y[i];
            w_nd[i] = r_bdir[i];
            case (r_bdir[i])
                DIR_RIGHT: begin
                    if (({1'b0, r_x[i]} + SPD11) > XLIM11) begin
                        w_nx[i] = XLIM10;
                        w_nd[i] = DIR_LEFT;
                    end else begin
                        w_nx[i] = r_x[i] + SPD10;
                    end
                end
                DIR_LEFT: begin
                    if (r_x[i] < SPD10) begin
                        w_nx[i] = '0;
                        w_nd[i] = DIR_RIGHT;
                    end else begin
                        w_nx[i] = r_x[i] - SPD10;
                    end
                end
                DIR_DOWN: begin
                    if (({1'b0, r_y[i]} + SPD11) > YLIM11) begin
                        w_ny[i] = YLIM10;
                        w_nd[i] = DIR_UP;
                    end else begin
                        w_ny[i] = r_y[i] + SPD10;
                    end
                end
                default: begin
                    if (r_y[i] < SPD10) begin
                        w_ny[i] = '0;
                        w_nd[i] = DIR_DOWN;
                    end else begin
                        w_ny[i] = r_y[i] - SPD10;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            r_prevX    <= TankX;
            r_prevY    <= TankY;
            r_dir      <= DIR_UP;
            r_firePrev <= 1'b0;
            r_fireAck  <= 1'b0;
            r_cooldown <= '0;
            r_active   <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                r_x[i]    <= '0;
                r_y[i]    <= '0;
                r_life[i] <= '0;
                r_bdir[i] <= DIR_UP;
            end
        end else begin
            r_prevX    <= TankX;
            r_prevY    <= TankY;
            r_dir      <= w_dirNext;
            r_firePrev <= w_fireNow;
            r_fireAck  <= w_spawn;
            if (w_spawn) begin
                r_cooldown <= CD_INIT;
            end else if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - CD_W'(1);
            end
            // A freshly spawned bullet does not move on its spawn frame.
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (w_spawn && (w_slot == SLOT_W'(i))) begin
                    r_active[i] <= 1'b1;
                    r_x[i]      <= w_spawnX[9:0];
                    r_y[i]      <= w_spawnY[9:0];
                    r_bdir[i]   <= r_dir;
                    r_life[i]   <= LIFE_INIT;
                end else if (r_active[i]) begin
                    if (r_life[i] == 10'd1) begin
                        r_active[i] <= 1'b0;
                    end else begin
                        r_life[i] <= r_life[i] - 10'd1;
                        r_x[i]    <= w_nx[i];
                        r_y[i]    <= w_ny[i];
                        r_bdir[i] <= w_nd[i];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_out
        assign BulletX[10*g +: 10] = r_x[g];
        assign BulletY[10*g +: 10] = r_y[g];
    end

    assign BulletActive = r_active;
    assign FireAck      = r_fireAck;

endmodule
